// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: IF presents an instruction, ID answers with ready.
// if_ready=0 asks fetch to hold if_instr/if_pc for another cycle.
interface decode_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned INSTR_WIDTH = 32;

  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [DATA_WIDTH-1:0]  if_pc;
  logic                   if_ready;

  modport master (output if_valid, if_instr, if_pc, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/decode_stage.sv
// MIPS ID stage: register operand fetch with MEM forwarding, control decode,
// load-use stall and branch flush, all captured into the ID/EX register.
module decode_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  decode_stage_if.slave             fetch,
  input  logic                      flush,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address_1,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address_2,
  input  logic [DATA_WIDTH-1:0]     rf_data_1,
  input  logic [DATA_WIDTH-1:0]     rf_data_2,
  input  logic                      mem_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_address,
  input  logic [DATA_WIDTH-1:0]     mem_write_data,
  output logic                      id_valid,
  output logic [DATA_WIDTH-1:0]     id_pc,
  output logic [5:0]                id_opcode,
  output logic [5:0]                id_funct,
  output logic [4:0]                id_shamt,
  output logic [DATA_WIDTH-1:0]     id_rs_data,
  output logic [DATA_WIDTH-1:0]     id_rt_data,
  output logic [DATA_WIDTH-1:0]     id_imm,
  output logic [REG_ADDR_WIDTH-1:0] id_dest,
  output logic                      id_reg_write,
  output logic                      id_mem_read,
  output logic                      id_mem_write,
  output logic                      id_illegal
);

  localparam int unsigned IMM_WIDTH = 16;

  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [IMM_WIDTH-1:0]      imm16;

  logic [REG_ADDR_WIDTH-1:0] dec_dest;
  logic                      dec_reg_write;
  logic                      dec_mem_read;
  logic                      dec_mem_write;
  logic                      dec_illegal;
  logic                      dec_uses_rt;
  logic [DATA_WIDTH-1:0]     dec_imm;

  logic [DATA_WIDTH-1:0]     rs_value;
  logic [DATA_WIDTH-1:0]     rt_value;
  logic                      stall_c;
  logic                      take_c;

  assign opcode = fetch.if_instr[31:26];
  assign funct  = fetch.if_instr[5:0];
  assign rs     = REG_ADDR_WIDTH'(fetch.if_instr[25:21]);
  assign rt     = REG_ADDR_WIDTH'(fetch.if_instr[20:16]);
  assign rd     = REG_ADDR_WIDTH'(fetch.if_instr[15:11]);
  assign imm16  = fetch.if_instr[15:0];

  assign rf_read_address_1 = rs;
  assign rf_read_address_2 = rt;

  // $0 reads as zero and is never forwarded; otherwise MEM result beats the file.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     rf_value
  );
    if (addr == '0)
      return '0;
    else if (mem_write_enable && (mem_write_address == addr))
      return mem_write_data;
    else
      return rf_value;
  endfunction

  assign rs_value = resolve(rs, rf_data_1);
  assign rt_value = resolve(rt, rf_data_2);

  always_comb begin
    dec_dest      = '0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_illegal   = 1'b0;
    dec_uses_rt   = 1'b0;
    dec_imm       = {{(DATA_WIDTH-IMM_WIDTH){imm16[IMM_WIDTH-1]}}, imm16};
    unique case (opcode)
      6'h00: begin
        dec_dest      = rd;
        dec_reg_write = (funct != 6'h08);
        dec_uses_rt   = 1'b1;
      end
      6'h08, 6'h09, 6'h0A: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
      end
      6'h0C, 6'h0D: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_imm       = DATA_WIDTH'(imm16);
      end
      6'h0F: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_imm       = DATA_WIDTH'({imm16, 16'h0000});
      end
      6'h23: begin
        dec_dest      = rt;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      6'h2B: begin
        dec_mem_write = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      6'h04, 6'h05: dec_uses_rt = 1'b1;
      6'h02:        dec_imm     = DATA_WIDTH'(fetch.if_instr[25:0]);
      default:      dec_illegal = 1'b1;
    endcase
    if (dec_dest == '0)
      dec_reg_write = 1'b0;
  end

  // Load in ID/EX whose result the decoding instruction needs: hold it one cycle.
  assign stall_c = id_valid && id_mem_read && (id_dest != '0) && fetch.if_valid &&
                   ((id_dest == rs) || (dec_uses_rt && (id_dest == rt)));

  assign fetch.if_ready = flush || !stall_c;
  assign take_c         = fetch.if_valid && !stall_c && !flush;

  // ID/EX register; data fields load unconditionally, control only on a real issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_opcode    <= '0;
      id_funct     <= '0;
      id_shamt     <= '0;
      id_rs_data   <= '0;
      id_rt_data   <= '0;
      id_imm       <= '0;
      id_dest      <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else begin
      id_valid     <= take_c;
      id_pc        <= fetch.if_pc;
      id_opcode    <= opcode;
      id_funct     <= funct;
      id_shamt     <= fetch.if_instr[10:6];
      id_rs_data   <= rs_value;
      id_rt_data   <= rt_value;
      id_imm       <= dec_imm;
      id_dest      <= dec_dest;
      id_reg_write <= take_c && dec_reg_write;
      id_mem_read  <= take_c && dec_mem_read;
      id_mem_write <= take_c && dec_mem_write;
      id_illegal   <= take_c && dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a cycle model of the ID/EX slot is compared
// every negedge, and literal expectations from hand-decoded words pin the model.
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [4:0]  rf_read_address_1;
  logic [4:0]  rf_read_address_2;
  logic [31:0] rf_data_1;
  logic [31:0] rf_data_2;
  logic        mem_write_enable;
  logic [4:0]  mem_write_address;
  logic [31:0] mem_write_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_illegal;

  decode_stage_if #(.DATA_WIDTH(32)) fif ();

  decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetch             (fif),
    .flush             (flush),
    .rf_read_address_1 (rf_read_address_1),
    .rf_read_address_2 (rf_read_address_2),
    .rf_data_1         (rf_data_1),
    .rf_data_2         (rf_data_2),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_opcode         (id_opcode),
    .id_funct          (id_funct),
    .id_shamt          (id_shamt),
    .id_rs_data        (id_rs_data),
    .id_rt_data        (id_rt_data),
    .id_imm            (id_imm),
    .id_dest           (id_dest),
    .id_reg_write      (id_reg_write),
    .id_mem_read       (id_mem_read),
    .id_mem_write      (id_mem_write),
    .id_illegal        (id_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } slot_t;

  slot_t m;

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return rf;
  endfunction

  // Fetch may advance unless a valid load in the slot feeds a register this instr reads.
  function automatic logic model_ready(input slot_t s, input logic v, input logic [31:0] ins,
                                       input logic fl);
    logic hazard;
    hazard = s.valid && s.mem_read && s.dest != 5'd0 && v &&
             (s.dest == ins[25:21] || (reads_rt(ins[31:26]) && s.dest == ins[20:16]));
    return fl || !hazard;
  endfunction

  function automatic slot_t model_next(input slot_t s);
    slot_t       n;
    logic [31:0] ins;
    logic [5:0]  op;
    n   = '{default: '0};
    ins = fif.if_instr;
    op  = ins[31:26];
    if (!fif.if_valid || flush || !model_ready(s, fif.if_valid, ins, flush)) return n;
    n.valid   = 1'b1;
    n.pc      = fif.if_pc;
    n.opcode  = op;
    n.funct   = ins[5:0];
    n.shamt   = ins[10:6];
    n.rs_data = operand(ins[25:21], rf_data_1, mem_write_enable, mem_write_address, mem_write_data);
    n.rt_data = operand(ins[20:16], rf_data_2, mem_write_enable, mem_write_address, mem_write_data);
    n.imm     = 32'(signed'(ins[15:0]));
    case (op)
      6'h00:               begin n.dest = ins[15:11]; n.reg_write = (ins[5:0] != 6'h08); end
      6'h08, 6'h09, 6'h0A: begin n.dest = ins[20:16]; n.reg_write = 1'b1; end
      6'h0C, 6'h0D:        begin n.dest = ins[20:16]; n.reg_write = 1'b1; n.imm = {16'h0, ins[15:0]}; end
      6'h0F:               begin n.dest = ins[20:16]; n.reg_write = 1'b1; n.imm = {ins[15:0], 16'h0}; end
      6'h23:               begin n.dest = ins[20:16]; n.reg_write = 1'b1; n.mem_read = 1'b1; end
      6'h2B:               n.mem_write = 1'b1;
      6'h04, 6'h05:        ;
      6'h02:               n.imm = {6'h0, ins[25:0]};
      default:             n.illegal = 1'b1;
    endcase
    if (n.dest == 5'd0) n.reg_write = 1'b0;
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '{default: '0};
    else       m <= model_next(m);
  end

  always @(negedge clock) begin
    chk("id_valid", 32'(id_valid), 32'(m.valid));
    chk("id_reg_write", 32'(id_reg_write), 32'(m.reg_write));
    chk("id_mem_read", 32'(id_mem_read), 32'(m.mem_read));
    chk("id_mem_write", 32'(id_mem_write), 32'(m.mem_write));
    chk("id_illegal", 32'(id_illegal), 32'(m.illegal));
    chk("if_ready", 32'(fif.if_ready), 32'(model_ready(m, fif.if_valid, fif.if_instr, flush)));
    chk("rf_read_address_1", 32'(rf_read_address_1), 32'(fif.if_instr[25:21]));
    chk("rf_read_address_2", 32'(rf_read_address_2), 32'(fif.if_instr[20:16]));
    if (m.valid) begin
      chk("id_pc", id_pc, m.pc);
      chk("id_opcode", 32'(id_opcode), 32'(m.opcode));
      chk("id_funct", 32'(id_funct), 32'(m.funct));
      chk("id_shamt", 32'(id_shamt), 32'(m.shamt));
      chk("id_rs_data", id_rs_data, m.rs_data);
      chk("id_rt_data", id_rt_data, m.rt_data);
      chk("id_imm", id_imm, m.imm);
      chk("id_dest", 32'(id_dest), 32'(m.dest));
    end
  end

  logic [31:0] pc_next = 32'h0000_1000;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    fif.if_valid      = v;
    fif.if_instr      = ins;
    fif.if_pc         = pc_next;
    pc_next           = pc_next + 32'd4;
    flush             = fl;
    rf_data_1         = r1;
    rf_data_2         = r2;
    mem_write_enable  = we;
    mem_write_address = wa;
    mem_write_data    = wd;
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    drive(1'b1, ins, 1'b0, r1, r2, 1'b0, 5'd0, 32'h0);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    #2;
    chk("reset id_valid", 32'(id_valid), 32'h0);
    chk("reset id_rs_data", id_rs_data, 32'h0);
    chk("reset if_ready", 32'(fif.if_ready), 32'h1);
    tick();
    reset = 1'b0;

    issue(32'h2023_0005, 32'hFFFF_FFE2, 32'h0);
    chk("addi valid", 32'(id_valid), 32'h1);
    chk("addi rs_data", id_rs_data, 32'hFFFF_FFE2);
    chk("addi imm", id_imm, 32'h5);
    chk("addi dest", 32'(id_dest), 32'h3);
    chk("addi reg_write", 32'(id_reg_write), 32'h1);

    issue(32'h8C44_0000, 32'h100, 32'h0);
    chk("lw mem_read", 32'(id_mem_read), 32'h1);
    drive(1'b1, 32'h0081_2820, 1'b0, 32'h5, 32'h11, 1'b0, 5'd0, 32'h0);
    chk("load-use if_ready", 32'(fif.if_ready), 32'h0);
    tick();
    chk("load-use bubble", 32'(id_valid), 32'h0);
    chk("after bubble if_ready", 32'(fif.if_ready), 32'h1);
    drive(1'b1, 32'h0081_2820, 1'b0, 32'h5, 32'h11, 1'b1, 5'd4, 32'h77);
    tick();
    chk("add valid", 32'(id_valid), 32'h1);
    chk("add dest", 32'(id_dest), 32'h5);
    chk("add fwd rs", id_rs_data, 32'h77);

    drive(1'b1, 32'h0022_1820, 1'b0, 32'hFFFF_FFE2, 32'h22, 1'b1, 5'd1, 32'h1234);
    tick();
    chk("mem fwd rs", id_rs_data, 32'h1234);
    chk("no fwd rt", id_rt_data, 32'h22);

    drive(1'b1, 32'h0000_1820, 1'b0, 32'hAAAA, 32'hBBBB, 1'b1, 5'd0, 32'hFFFF);
    tick();
    chk("zero reg rs", id_rs_data, 32'h0);
    issue(32'h2000_0007, 32'h0, 32'h0);
    chk("dest0 valid", 32'(id_valid), 32'h1);
    chk("dest0 reg_write", 32'(id_reg_write), 32'h0);

    issue(32'h8C44_0000, 32'h100, 32'h0);
    drive(1'b1, 32'h0081_2820, 1'b1, 32'h5, 32'h11, 1'b0, 5'd0, 32'h0);
    chk("flush if_ready", 32'(fif.if_ready), 32'h1);
    tick();
    chk("flush bubble", 32'(id_valid), 32'h0);
    drive(1'b1, 32'h2023_0005, 1'b0, 32'h9, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("post-flush if_ready", 32'(fif.if_ready), 32'h1);
    tick();
    chk("post-flush valid", 32'(id_valid), 32'h1);

    issue(32'h8C44_0000, 32'h100, 32'h0);
    drive(1'b1, 32'h2024_0001, 1'b0, 32'h3, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("addi rt no stall", 32'(fif.if_ready), 32'h1);
    tick();
    issue(32'h8C44_0000, 32'h100, 32'h0);
    drive(1'b1, 32'hAC24_0000, 1'b0, 32'h3, 32'h44, 1'b0, 5'd0, 32'h0);
    chk("sw rt stall", 32'(fif.if_ready), 32'h0);
    tick();
    tick();
    chk("sw mem_write", 32'(id_mem_write), 32'h1);

    issue(32'h3022_FFFF, 32'h0, 32'h0);
    chk("andi imm", id_imm, 32'h0000_FFFF);
    issue(32'h3C03_ABCD, 32'h0, 32'h0);
    chk("lui imm", id_imm, 32'hABCD_0000);
    issue(32'hFC00_0000, 32'h0, 32'h0);
    chk("illegal flag", 32'(id_illegal), 32'h1);
    chk("illegal reg_write", 32'(id_reg_write), 32'h0);
    issue(32'h0800_0010, 32'h0, 32'h0);
    chk("j imm", id_imm, 32'h10);
    issue(32'h03E0_0008, 32'h40, 32'h0);
    chk("jr reg_write", 32'(id_reg_write), 32'h0);
    issue(32'h1022_FFFE, 32'h1, 32'h2);
    chk("beq imm", id_imm, 32'hFFFF_FFFE);
    drive(1'b0, 32'h2023_0005, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("if_valid=0 bubble", 32'(id_valid), 32'h0);

    issue(32'h8C44_0000, 32'h100, 32'h0);
    drive(1'b1, 32'h0081_2820, 1'b0, 32'h5, 32'h11, 1'b0, 5'd0, 32'h0);
    chk("pre-reset stall", 32'(fif.if_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("mid-stall reset valid", 32'(id_valid), 32'h0);
    chk("mid-stall reset mem_read", 32'(id_mem_read), 32'h0);
    chk("mid-stall reset if_ready", 32'(fif.if_ready), 32'h1);
    tick();
    reset = 1'b0;
    tick();
    chk("held add issues", 32'(id_valid), 32'h1);
    chk("held add dest", 32'(id_dest), 32'h5);

    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode (ID) stage of the 5-stage MIPS pipeline.
- Drives the register file read addresses from the fetched instruction and takes the 32-bit operands it returns.
- Applies MEM-stage forwarding and $0 masking, decodes control fields, and registers everything into the ID/EX pipeline register.
- Detects load-use hazards and stalls fetch by one cycle, inserting a bubble. Honours branch flush from EX.

Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clock  in  1  pipeline clock; the ID/EX register updates on posedge.
- reset  in  1  asynchronous, active-high; clears the ID/EX register.
- if_valid  in  1  if_instr/if_pc hold a real instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- if_ready  out  1  0 = IF must hold instr/pc this cycle (stall).
- flush  in  1  branch/jump redirect from EX; kill the instruction in decode.
- rf_read_address_1  out  5  combinational, equal to if_instr[25:21] (rs).
- rf_read_address_2  out  5  combinational, equal to if_instr[20:16] (rt).
- rf_data_1  in  32  rs operand; valid before posedge (register file reads on negedge).
- rf_data_2  in  32  rt operand; same timing.
- mem_write_enable  in  1  MEM stage will write the register file next cycle.
- mem_write_address  in  5  its destination register.
- mem_write_data  in  32  its result.
- id_valid  out  1  ID/EX slot holds a real instruction.
- id_pc  out  32  registered PC.
- id_opcode  out  6  instr[31:26].
- id_funct  out  6  instr[5:0].
- id_shamt  out  5  instr[10:6].
- id_rs_data  out  32  resolved rs operand.
- id_rt_data  out  32  resolved rt operand.
- id_imm  out  32  extended immediate.
- id_dest  out  5  write-back register.
- id_reg_write  out  1  instruction writes a register.
- id_mem_read  out  1  load.
- id_mem_write  out  1  store.
- id_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (async): every id_* output is 0. if_ready is combinational and is 1 while in reset.
- Latency: one cycle. The instruction presented with if_valid=1 and if_ready=1 at posedge N appears on id_* after posedge N.
- Operand resolution, per operand, in priority order:
  - address 0: result is 0. $0 is never forwarded.
  - mem_write_enable=1 and mem_write_address equals the operand address: result is mem_write_data.
  - otherwise: result is rf_data.
  - No WB bypass is needed; a same-cycle register file write is visible at the negedge read.
- Decode by opcode:
  - 0x00 R-type: dest=rd. reg_write=1 except funct 0x08 (jr).
  - 0x08/0x09/0x0A (addi/addiu/slti): dest=rt, reg_write=1, imm sign-extended.
  - 0x0C/0x0D (andi/ori): dest=rt, reg_write=1, imm zero-extended.
  - 0x0F (lui): dest=rt, reg_write=1, imm = instr[15:0]<<16.
  - 0x23 (lw): dest=rt, reg_write=1, mem_read=1, imm sign-extended.
  - 0x2B (sw): mem_write=1, imm sign-extended.
  - 0x04/0x05 (beq/bne): imm sign-extended, no write.
  - 0x02 (j): imm = instr[25:0] zero-extended.
  - any other opcode: id_illegal=1, with reg_write/mem_read/mem_write forced to 0.
  - dest=0 forces id_reg_write=0.
- uses_rt is true for R-type, sw, beq and bne.
- Load-use stall condition (combinational): id_valid & id_mem_read & (id_dest!=0) & if_valid & ((id_dest==rs) | (uses_rt & id_dest==rt)).
- When the stall condition holds: if_ready=0. The next posedge loads a bubble (id_valid=0, all control bits 0). The stall lasts exactly one cycle because the bubble clears the condition.
- flush=1 has top priority:
  - if_ready=1 regardless of stall.
  - next posedge loads a bubble.
  - The instruction on if_instr is discarded.
- if_valid=0: the next posedge loads a bubble.
- Data fields are don't-care when id_valid=0; control bits must be 0.
- Reset asserted mid-stall: all outputs clear immediately. After release, the held instruction issues without a stall.

Test Plan:
- Reset; if_instr=0x20230005 (addi $3,$1,5), rf_data_1=0xFFFFFFE2 -> after 1 posedge: id_valid=1, id_rs_data=0xFFFFFFE2, id_imm=5, id_dest=3, id_reg_write=1.
- 0x8C440000 (lw $4,0($2)) then 0x00812820 (add $5,$4,$1) -> if_ready=0 for one cycle, one bubble (id_valid=0), then add issues with id_dest=5; mem_write_address=4, data 0x77 on that cycle -> id_rs_data=0x77.
- mem_write_enable=1, address 1, data 0x1234, rf_data_1=0xFFFFFFE2, add with rs=1 -> id_rs_data=0x1234.
- mem write to $0 with 0xFFFF; instr reads rs=0 -> id_rs_data=0. Then 0x20000007 (addi $0,$0,7) -> id_reg_write=0.
- Load-use condition plus flush=1 in the same cycle -> if_ready=1; next posedge id_valid=0, no extra stall cycle.
- 0x3022FFFF (andi) -> id_imm=0x0000FFFF. 0x3C03ABCD (lui) -> id_imm=0xABCD0000. 0xFC000000 -> id_illegal=1, id_reg_write=0.
